// File: rtl/divider_pkg.sv
// Shared FSM encoding and default widths for the sequential restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIVIDEND_W_DEF = 8;
  localparam int DIVISOR_W_DEF  = 4;

  // Iteration counter width; never zero so a 1-bit dividend still has a counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between a divider client and the divider core.
// div_by_zero exists only when DIVIDER_ZERO_DETECT_EN is defined.
interface seq_divider_if
  import divider_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
);
  logic                  start_vld;
  logic [DIVIDEND_W-1:0] dividend_dat;
  logic [DIVISOR_W-1:0]  divisor_dat;
  logic [DIVIDEND_W-1:0] quotient_dat;
  logic [DIVISOR_W-1:0]  remainder_dat;
  logic                  busy;
  logic                  done_vld;
`ifdef DIVIDER_ZERO_DETECT_EN
  logic                  div_by_zero;
`endif

  modport master (
    output start_vld, dividend_dat, divisor_dat,
`ifdef DIVIDER_ZERO_DETECT_EN
    input  div_by_zero,
`endif
    input  quotient_dat, remainder_dat, busy, done_vld
  );

  modport slave (
    input  start_vld, dividend_dat, divisor_dat,
`ifdef DIVIDER_ZERO_DETECT_EN
    output div_by_zero,
`endif
    output quotient_dat, remainder_dat, busy, done_vld
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits.
module div_step #(
  parameter int DIVISOR_W = 4
) (
  input  logic [DIVISOR_W:0]   prem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W:0]   prem_o,
  output logic                 qbit_o
);

  // One extra bit keeps the compare exact even when a zero divisor lets the remainder grow.
  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W+1:0] divisor_ext;

  assign shifted     = {prem_i, bit_i};
  assign divisor_ext = {2'b00, divisor_i};

  always_comb begin
    qbit_o = 1'b0;
    prem_o = shifted[DIVISOR_W:0];
    if (shifted >= divisor_ext) begin
      qbit_o = 1'b1;
      prem_o = (DIVISOR_W+1)'(shifted - divisor_ext);
    end
  end

endmodule

// File: rtl/seq_divider_core.sv
// IDLE/RUN/DONE controller: one quotient bit per RUN cycle, results registered on exit.
// DIVIDER_ZERO_DETECT_EN short-circuits a zero divisor straight to DONE with a flag.
module seq_divider_core
  import divider_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  seq_divider_if.slave bus
);

  localparam int CNT_W = cnt_width(DIVIDEND_W);

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  // Dividend bits leave at the top while quotient bits enter at the bottom.
  logic [DIVIDEND_W-1:0] work_q;
  logic [DIVISOR_W-1:0]  divisor_q;
  logic [DIVISOR_W:0]    prem_q;
  logic [DIVIDEND_W-1:0] quotient_q;
  logic [DIVISOR_W-1:0]  remainder_q;
  logic                  busy_q;
  logic                  done_q;
  logic [DIVISOR_W:0]    prem_d;
  logic                  qbit_d;
`ifdef DIVIDER_ZERO_DETECT_EN
  logic                  dbz_q;
`endif

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .prem_i    (prem_q),
    .bit_i     (work_q[DIVIDEND_W-1]),
    .divisor_i (divisor_q),
    .prem_o    (prem_d),
    .qbit_o    (qbit_d)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      divisor_q   <= '0;
      prem_q      <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DIVIDER_ZERO_DETECT_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start_vld) begin
            work_q    <= bus.dividend_dat;
            divisor_q <= bus.divisor_dat;
            prem_q    <= '0;
            cnt_q     <= CNT_W'(DIVIDEND_W - 1);
`ifdef DIVIDER_ZERO_DETECT_EN
            dbz_q <= (bus.divisor_dat == '0);
            if (bus.divisor_dat == '0) begin
              quotient_q  <= '1;
              remainder_q <= bus.dividend_dat[DIVISOR_W-1:0];
              done_q      <= 1'b1;
              state_q     <= DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
`else
            busy_q  <= 1'b1;
            state_q <= RUN;
`endif
          end
        end
        RUN: begin
          prem_q <= prem_d;
          work_q <= {work_q[DIVIDEND_W-2:0], qbit_d};
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            quotient_q  <= {work_q[DIVIDEND_W-2:0], qbit_d};
            remainder_q <= prem_d[DIVISOR_W-1:0];
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.quotient_dat  = quotient_q;
  assign bus.remainder_dat = remainder_q;
  assign bus.busy          = busy_q;
  assign bus.done_vld      = done_q;
`ifdef DIVIDER_ZERO_DETECT_EN
  assign bus.div_by_zero   = dbz_q;
`endif

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider top: flat ports onto the internal request/result bundle.
// oDivByZero is present only when DIVIDER_ZERO_DETECT_EN is defined.
module seq_divider
  import divider_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [DIVIDEND_W-1:0] iDividend,
  input  logic [DIVISOR_W-1:0]  iDivisor,
  output logic [DIVIDEND_W-1:0] oQuotient,
  output logic [DIVISOR_W-1:0]  oRemainder,
  output logic                  oBusy,
`ifdef DIVIDER_ZERO_DETECT_EN
  output logic                  oDivByZero,
`endif
  output logic                  oDone
);

  seq_divider_if #(.DIVIDEND_W(DIVIDEND_W), .DIVISOR_W(DIVISOR_W)) bus ();

  assign bus.start_vld    = iStart;
  assign bus.dividend_dat = iDividend;
  assign bus.divisor_dat  = iDivisor;
  assign oQuotient        = bus.quotient_dat;
  assign oRemainder       = bus.remainder_dat;
  assign oBusy            = bus.busy;
  assign oDone            = bus.done_vld;
`ifdef DIVIDER_ZERO_DETECT_EN
  assign oDivByZero       = bus.div_by_zero;
`endif

  seq_divider_core #(.DIVIDEND_W(DIVIDEND_W), .DIVISOR_W(DIVISOR_W)) u_core (
    .clk_i (Clock),
    .rst_i (Reset),
    .bus   (bus.slave)
  );

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter DIVIDEND_W, default 8, meaning dividend and quotient width in bits.
REQ-002 SHALL have parameter DIVISOR_W, default 4, meaning divisor and remainder width in bits.
REQ-003 SHALL have port Clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port iStart, input, 1, request to begin a division; sampled only in IDLE.
REQ-006 SHALL have port iDividend, input, DIVIDEND_W, unsigned dividend; captured when iStart is accepted.
REQ-007 SHALL have port iDivisor, input, DIVISOR_W, unsigned divisor; captured when iStart is accepted.
REQ-008 SHALL have port oQuotient, output, DIVIDEND_W, registered quotient.
REQ-009 SHALL have port oRemainder, output, DIVISOR_W, registered remainder.
REQ-010 SHALL have port oBusy, output, 1, high while in RUN.
REQ-011 SHALL have port oDone, output, 1, one-cycle pulse marking valid results.
REQ-012 SHALL have port oDivByZero, output, 1, present only when DIVIDER_ZERO_DETECT_EN is defined.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 SHALL, in IDLE with iStart=1, latch both operands, clear the partial remainder (DIVISOR_W+1 bits), load the iteration counter to DIVIDEND_W-1 and enter RUN.
REQ-015 SHALL, in each RUN cycle, apply one restoring step MSB first: shift the next dividend bit into the partial remainder; if partial remainder >= divisor, subtract the divisor and set the quotient bit to 1, else keep it and set the bit to 0.
REQ-016 SHALL leave RUN after exactly DIVIDEND_W cycles, registering oQuotient/oRemainder on that edge and entering DONE.
REQ-017 SHALL assert oDone only in DONE, for exactly one cycle (DIVIDEND_W+1 cycles after the accepting edge), then return to IDLE.
REQ-018 SHALL hold oQuotient/oRemainder stable from DONE until the next accepted iStart updates them.
REQ-019 SHALL ignore iStart in RUN and DONE; no queuing and no effect on the operation in progress.
REQ-020 SHALL, for a zero divisor without the macro, run the normal algorithm, yielding quotient all-ones and remainder = iDividend[DIVISOR_W-1:0].
REQ-021 SHALL keep iDividend/iDivisor changes after acceptance from affecting the result.

Reset
REQ-022 SHALL, on Reset=1 at a rising edge, enter IDLE and clear oQuotient, oRemainder, oBusy, oDone, oDivByZero and internal registers to 0, in any state.
REQ-023 SHALL give Reset priority over iStart in the same cycle; an operation aborted by Reset produces no oDone.

Configuration
REQ-024 SHALL, with DIVIDER_ZERO_DETECT_EN defined, detect divisor==0 at acceptance, skip RUN, go IDLE->DONE, output quotient all-ones, remainder = iDividend[DIVISOR_W-1:0], and hold oDivByZero=1 with the results until the next accepted iStart.
REQ-025 SHALL, without DIVIDER_ZERO_DETECT_EN, omit the oDivByZero port and its logic, using REQ-020 behaviour.

Structure
REQ-026 SHALL place the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default width constants in shared package divider_pkg.
REQ-027 SHALL implement one restoring step as combinational sub-module div_step (inputs: partial remainder, next bit, divisor; outputs: new partial remainder, quotient bit), instantiated once.

Verification
REQ-028 SHALL cover: 200/7 -> oQuotient=28, oRemainder=4, oDone pulse exactly 9 cycles after start edge, oBusy high 8 cycles.
REQ-029 SHALL cover: 255/15 -> 17 r0; 13/14 -> 0 r13; 0/5 -> 0 r0.
REQ-030 SHALL cover: 100/0 -> 0xFF r4; with macro, oDone 1 cycle after start and oDivByZero=1; without macro, 9 cycles and no flag port.
REQ-031 SHALL cover: iStart pulsed and operands changed during RUN (first op 200/7) -> single oDone, result still 28 r4.
REQ-032 SHALL cover: Reset asserted in the 4th RUN cycle -> IDLE next cycle, all outputs 0, no oDone; a following 50/6 -> 8 r2.
REQ-033 SHALL cover: exhaustive sweep of all dividend/divisor pairs with nonzero divisor -> quotient*divisor+remainder==dividend and remainder<divisor.
